// File: rtl/nios_system_ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package nios_system_ram_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/nios_system_ram_arb_rr.sv
// Two-way round-robin grant with a last-granted pointer; the pointer moves only on a grant.
module nios_system_ram_arb_rr
  import nios_system_ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant
);

  // Index of the master granted last; resets to 1 so master 0 wins first contention.
  logic last_q, last_d;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (grant[1]) begin
      last_d = 1'b1;
    end else if (grant[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/nios_system_ram_arb.sv
// Two-master arbiter for a latency-1 on-chip RAM: round-robin per cycle, optional
// bounded lock ownership when NIOS_SYSTEM_RAM_ARB_LOCK_EN is defined.
module nios_system_ram_arb
  import nios_system_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                reset_n,
`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  // The entry grant is taken in IDLE, so OWNn leaves after MAX_HOLD-1 further grants.
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 1) ? MAX_HOLD - 2 : 0;

  logic [NUM_MASTERS-1:0] req, req_elig, grant, lock;
  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   rd_pend_q, rd_pend_d, rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0]      rdata0_q, rdata1_q;

  assign req = {m1_read | m1_write, m0_read | m0_write};

`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
  assign lock = {m1_lock, m0_lock};
`else
  assign lock = '0;
`endif

  nios_system_ram_arb_rr u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_elig),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (grant[0] && lock[0]) begin
          state_d = OWN0;
        end else if (grant[1] && lock[1]) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        hold_d = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
        if (!lock[0] || hold_q >= HOLD_W'(HOLD_LAST)) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        hold_d = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
        if (!lock[1] || hold_q >= HOLD_W'(HOLD_LAST)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requests are masked while in reset and to the owner while locked.
  always_comb begin
    req_elig = req & {NUM_MASTERS{reset_n}};
    unique case (state_q)
      OWN0:    req_elig[1] = 1'b0;
      OWN1:    req_elig[0] = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    ram_address    = grant[1] ? m1_address    : m0_address;
    ram_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
    ram_writedata  = grant[1] ? m1_writedata  : m0_writedata;
    ram_chipselect = |grant;
    ram_write      = (grant[0] & m0_write) | (grant[1] & m1_write);
    ram_clken      = reset_n;
    m0_waitrequest = ~grant[0];
    m1_waitrequest = ~grant[1];
  end

  assign rd_pend_d = (grant[0] & m0_read) | (grant[1] & m1_read);
  assign rd_tag_d  = grant[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
      if (m0_readdatavalid) begin
        rdata0_q <= ram_readdata;
      end
      if (m1_readdatavalid) begin
        rdata1_q <= ram_readdata;
      end
    end
  end

  // RAM output is only meaningful the cycle after a read; otherwise show the last value.
  always_comb begin
    m0_readdatavalid = rd_pend_q & ~rd_tag_q;
    m1_readdatavalid = rd_pend_q & rd_tag_q;
    m0_readdata      = m0_readdatavalid ? ram_readdata : rdata0_q;
    m1_readdata      = m1_readdatavalid ? ram_readdata : rdata1_q;
  end

endmodule

// File: tb/tb_nios_system_ram_arb.sv
// Self-checking bench: behavioural latency-1 RAM, read-data scoreboard and directed arbitration checks.
module tb_nios_system_ram_arb;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned MAX_HOLD = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [ADDR_W-1:0] addr [2];
  logic [BE_W-1:0]   be   [2];
  logic [DATA_W-1:0] wd   [2];
  logic [1:0]        rd, wr, lk;

  logic              m0_wait, m1_wait, m0_vld, m1_vld;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [1:0]        waitreq, vld;
  logic [DATA_W-1:0] rdata [2];

  logic [ADDR_W-1:0] ram_address, ram_addr_q;
  logic [BE_W-1:0]   ram_byteenable;
  logic [DATA_W-1:0] ram_writedata, ram_readdata;
  logic              ram_chipselect, ram_write, ram_clken;

  logic [DATA_W-1:0] mem     [1 << ADDR_W];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  logic [DATA_W-1:0] sb0 [$];
  logic [DATA_W-1:0] sb1 [$];
  logic [1:0]        exp_vld;
  int                vld_cnt [2];
  int                n_vec = 0;
  int                n_err = 0;

  assign waitreq  = {m1_wait, m0_wait};
  assign vld      = {m1_vld, m0_vld};
  assign rdata[0] = m0_rdata;
  assign rdata[1] = m1_rdata;

  always #5 clk = ~clk;

  nios_system_ram_arb #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
    .m0_lock          (lk[0]),
    .m1_lock          (lk[1]),
`endif
    .m0_address       (addr[0]),
    .m0_byteenable    (be[0]),
    .m0_read          (rd[0]),
    .m0_write         (wr[0]),
    .m0_writedata     (wd[0]),
    .m0_waitrequest   (m0_wait),
    .m0_readdata      (m0_rdata),
    .m0_readdatavalid (m0_vld),
    .m1_address       (addr[1]),
    .m1_byteenable    (be[1]),
    .m1_read          (rd[1]),
    .m1_write         (wr[1]),
    .m1_writedata     (wd[1]),
    .m1_waitrequest   (m1_wait),
    .m1_readdata      (m1_rdata),
    .m1_readdatavalid (m1_vld),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_writedata    (ram_writedata),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  // Registered address, unregistered data: read latency 1.
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end
      ram_addr_q <= ram_address;
    end
  end
  assign ram_readdata = mem[ram_addr_q];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: expected read data pushed on acceptance, popped on readdatavalid.
  always @(negedge clk) begin
    logic [1:0] nxt;
    nxt = '0;
    if (!reset_n) begin
      exp_vld = '0;
      sb0.delete();
      sb1.delete();
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (exp_vld[n] || vld[n]) check_eq("rd_valid", 64'(vld[n]), 64'(exp_vld[n]));
        if (vld[n]) begin
          vld_cnt[n]++;
          if (n == 0 && sb0.size() > 0) check_eq("rd_data_m0", 64'(rdata[0]), 64'(sb0.pop_front()));
          if (n == 1 && sb1.size() > 0) check_eq("rd_data_m1", 64'(rdata[1]), 64'(sb1.pop_front()));
        end
      end
      for (int n = 0; n < 2; n++) begin
        if ((rd[n] || wr[n]) && !waitreq[n]) begin
          if (wr[n]) begin
            for (int b = 0; b < int'(BE_W); b++) begin
              if (be[n][b]) ref_mem[addr[n]][8*b +: 8] = wd[n][8*b +: 8];
            end
          end else begin
            if (n == 0) sb0.push_back(ref_mem[addr[n]]);
            else        sb1.push_back(ref_mem[addr[n]]);
            nxt[n] = 1'b1;
          end
        end
      end
      exp_vld = nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic xfer(input int m, input bit is_wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    int t;
    t = 0;
    addr[m] = a; wd[m] = d; be[m] = b;
    rd[m] = !is_wr; wr[m] = is_wr;
    @(negedge clk);
    while (waitreq[m] && t < 20) begin
      t++;
      @(negedge clk);
    end
    if (waitreq[m]) check_eq("xfer_timeout", 64'(waitreq[m]), 64'd0);
    step();
    rd[m] = 1'b0; wr[m] = 1'b0;
  endtask

  initial begin
    logic [1:0] e;
    int n0;
    bit got1;
    for (int n = 0; n < 2; n++) begin
      addr[n] = '0; be[n] = '0; wd[n] = '0;
    end
    rd = '0; wr = '0; lk = '0;
    exp_vld = '0;
    vld_cnt[0] = 0; vld_cnt[1] = 0;

    // Reset state, with requests present
    rd[0] = 1'b1; wr[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_wait", 64'(waitreq), 64'b11);
    check_eq("rst_vld", 64'(vld), 64'b00);
    check_eq("rst_rdata0", 64'(m0_rdata), 64'd0);
    check_eq("rst_rdata1", 64'(m1_rdata), 64'd0);
    check_eq("rst_cs", 64'(ram_chipselect), 64'd0);
    check_eq("rst_we", 64'(ram_write), 64'd0);
    check_eq("rst_clken", 64'(ram_clken), 64'd0);
    rd = '0; wr = '0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_cs", 64'(ram_chipselect), 64'd0);
    check_eq("idle_we", 64'(ram_write), 64'd0);
    check_eq("clken", 64'(ram_clken), 64'd1);
    step();

    // Write then read back on m0
    xfer(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 10'd5, 32'h0, 4'h0);
    check_eq("m0_rb_vld", 64'(vld), 64'b01);
    check_eq("m0_rb_data", 64'(m0_rdata), 64'hDEADBEEF);

    // Partial-byte write on m1 at top address
    xfer(1, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF);
    xfer(1, 1'b1, 10'h3FF, 32'h11223344, 4'h3);
    xfer(1, 1'b0, 10'h3FF, 32'h0, 4'h0);
    check_eq("m1_be_vld", 64'(vld), 64'b10);
    check_eq("m1_be_data", 64'(m1_rdata), 64'hFFFF3344);
    check_eq("m0_hold", 64'(m0_rdata), 64'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, ADDR_W'(i), $urandom, 4'hF);
      xfer(1, 1'b1, ADDR_W'(10'h100 + i), $urandom, 4'hF);
    end

    // Both masters read every cycle: strict alternation starting with m0
    vld_cnt[0] = 0; vld_cnt[1] = 0;
    rd = 2'b11;
    for (int i = 0; i < 8; i++) begin
      addr[0] = ADDR_W'(i % 4);
      addr[1] = ADDR_W'(10'h100 + (i % 4));
      @(negedge clk);
      e = (i % 2 == 0) ? 2'b10 : 2'b01;
      check_eq("rr_wait", 64'(waitreq), 64'(e));
      check_eq("rr_cs", 64'(ram_chipselect), 64'd1);
      step();
    end
    rd = '0;
    repeat (2) step();
    check_eq("rr_vld_m0", 64'(vld_cnt[0]), 64'd4);
    check_eq("rr_vld_m1", 64'(vld_cnt[1]), 64'd4);

    // Single requester: no wait states
    vld_cnt[1] = 0;
    rd[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[1] = ADDR_W'(10'h100 + i);
      @(negedge clk);
      check_eq("single_wait", 64'(waitreq[1]), 64'd0);
      step();
    end
    rd[1] = 1'b0;
    @(negedge clk);
    check_eq("post_cs", 64'(ram_chipselect), 64'd0);
    step();
    check_eq("single_vld", 64'(vld_cnt[1]), 64'd3);

    // Reset right after an accepted read cancels its strobe
    rd[0] = 1'b1; addr[0] = 10'd1;
    @(negedge clk);
    check_eq("mid_acc", 64'(waitreq[0]), 64'd0);
    step();
    rd[0] = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("mid_vld", 64'(vld), 64'b00);
    check_eq("mid_rdata0", 64'(m0_rdata), 64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    rd = 2'b11; addr[0] = 10'd1; addr[1] = 10'h102;
    @(negedge clk);
    check_eq("post_rst_m0", 64'(waitreq), 64'b10);
    step();
    @(negedge clk);
    check_eq("post_rst_m1", 64'(waitreq), 64'b01);
    step();
    rd = '0;
    step();

`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
    // m0 locked under contention: bounded by MAX_HOLD grants, then m1
    lk[0] = 1'b1; rd = 2'b11; addr[1] = 10'h101;
    n0 = 0; got1 = 1'b0;
    for (int c = 0; c < 40 && !got1; c++) begin
      @(negedge clk);
      if (!waitreq[0]) n0++;
      if (!waitreq[1]) got1 = 1'b1;
      step();
    end
    rd = '0; lk = '0;
    check_eq("lock_grants", 64'(n0), 64'(MAX_HOLD));
    check_eq("lock_handoff", 64'(got1), 64'd1);
`else
    n0 = 0; got1 = 1'b0;
`endif

    repeat (3) step();
    check_eq("sb_empty", 64'(sb0.size() + sb1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios_system_ram_arb.md
NIOS_SYSTEM_RAM_ARB -- requirements
Module: nios_system_ram_arb

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, meaning data width; byteenable width is DATA_W/8.
REQ-003 Parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one master may own the RAM under lock.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mN_address  in  ADDR_W  word address, for N = 0 and 1.
REQ-007 mN_byteenable  in  DATA_W/8  write byte lanes.
REQ-008 mN_read / mN_write  in  1 each  transfer request; asserting both at once is illegal.
REQ-009 mN_writedata  in  DATA_W  write data.
REQ-010 mN_waitrequest  out  1  high while the request is not accepted this cycle.
REQ-011 mN_readdata  out  DATA_W  read return data.
REQ-012 mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata.
REQ-013 ram_address / ram_byteenable / ram_writedata  out  ADDR_W / DATA_W/8 / DATA_W  shared RAM port.
REQ-014 ram_chipselect / ram_write / ram_clken  out  1 each  RAM control.
REQ-015 ram_readdata  in  DATA_W  RAM output; registered address, unregistered output, read latency 1.

Function
REQ-016 A request shall be accepted in the cycle its master is granted; mN_waitrequest shall be low only in that cycle, and only while that master is requesting.
REQ-017 At most one master shall be granted per cycle; an idle cycle (no request) shall drive ram_chipselect=0 and ram_write=0.
REQ-018 The granted master's address, byteenable and writedata shall be muxed combinationally to the RAM; ram_write = granted & mN_write.
REQ-019 ram_clken shall be 1 whenever reset_n is high.
REQ-020 Round-robin: on contention, grant the master not granted last; the pointer updates only on an accepted transfer.
REQ-021 With no prior grant since reset, master 0 shall win contention.
REQ-022 A read accepted in cycle T shall give mN_readdatavalid=1 with mN_readdata=ram_readdata in cycle T+1, for the originating master only; a registered 1-bit tag records the owner.
REQ-023 Back-to-back reads from alternating masters shall sustain one transfer per cycle, with no bubble.
REQ-024 Readdata of the non-valid master shall be held at its last value, not zeroed.
REQ-025 FSM states shall be IDLE, OWN0 and OWN1; OWNn is entered on a locked grant (see Configuration), otherwise IDLE is held.
REQ-026 In OWNn only master n is granted; exit to IDLE when its lock drops or when the hold counter reaches MAX_HOLD.
REQ-027 A forced exit at MAX_HOLD shall grant the other master on the next cycle if it is requesting; otherwise OWNn may be re-entered.
REQ-028 The hold counter shall clear on entry to OWNn and shall saturate at MAX_HOLD.

Reset
REQ-029 While reset_n=0: mN_waitrequest=1, mN_readdatavalid=0, mN_readdata=0, ram_chipselect=0, ram_write=0, ram_clken=0, FSM=IDLE, pointer favours m0, hold counter=0.
REQ-030 Asserting reset mid-read shall cancel the pending readdatavalid.
REQ-031 Release is synchronous to clk; the first grant is possible in the first cycle after release.

Configuration
REQ-032 Macro NIOS_SYSTEM_RAM_ARB_LOCK_EN: when defined, add input ports mN_lock (1 bit each); a granted request with mN_lock=1 enters OWNn.
REQ-033 Without NIOS_SYSTEM_RAM_ARB_LOCK_EN: no lock ports exist, the FSM stays in IDLE, and arbitration is pure per-cycle round-robin.

Structure
REQ-034 Package nios_system_ram_arb_pkg shall hold the FSM state enum (IDLE, OWN0, OWN1) and the constant NUM_MASTERS=2.
REQ-035 One sub-module, nios_system_ram_arb_rr, shall hold the 2-way round-robin grant plus pointer; the mux, FSM and read tag stay in the top level.

Verification
REQ-036 m0 writes 0xDEADBEEF to address 5 with byteenable 0xF, then reads address 5 -> m0_readdatavalid one cycle after acceptance with data 0xDEADBEEF; m1_readdatavalid stays 0.
REQ-037 Both masters read every cycle for 8 cycles -> grants alternate m0,m1,m0,...; each master gets 4 readdatavalid strobes; ram_chipselect is high all 8 cycles.
REQ-038 m1 writes 0x11223344 to address 0x3FF with byteenable 0x3 over prior 0xFFFFFFFF -> readback 0xFFFF3344.
REQ-039 With LOCK_EN, m0 holds lock and requests continuously while m1 requests -> m0 gets exactly 16 grants, then m1 is granted on the next cycle.
REQ-040 Reset asserted the cycle after an accepted read -> no readdatavalid; after release, contention goes to m0.
REQ-041 A single requester issues reads for 3 cycles -> zero waitrequest cycles and 3 valid strobes at T+1.
